// File: rtl/mult_sequencer.sv
// Iterative signed shift-add multiplier owning the HI/LO pair for MULT/MFLO.
// Latency: start sampled at E0, done pulses in the cycle after edge E0+WIDTH.
// No backpressure: start is ignored while busy; hi/lo hold the last product.
module mult_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNTW-1:0]  LAST = CNTW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNTW-1:0]    count;
   logic               neg;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] product;

   // An unsigned W-bit magnitude represents |-2^(W-1)| exactly.
   always_comb begin
      a_mag    = a[WIDTH-1] ? (~a + ONE) : a;
      b_mag    = b[WIDTH-1] ? (~b + ONE) : b;
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      acc_next = {sum, acc[WIDTH-1:1]};
      product  = neg ? (~acc_next + 1'b1) : acc_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= RUN;
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
               done <= 1'b0;
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  {hi, lo}     <= product;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: directed literal cases plus randomized traffic vs a product model.
module tb_mult_sequencer;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   int n_chk = 0;
   int n_pass = 0;

   mult_sequencer #(.WIDTH(W), .CNTW(6)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Model: a product takes W edges after acceptance, then shows up with a one-cycle done.
   int          rem = 0;
   logic [63:0] m_prod = '0;
   logic [63:0] m_hilo = '0;
   bit          m_done = 1'b0;

   function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem    <= 0;
         m_hilo <= '0;
         m_done <= 1'b0;
      end else begin
         int          r;
         bit          d;
         logic [63:0] hl;
         logic [63:0] p;
         r  = rem;
         d  = 1'b0;
         hl = m_hilo;
         p  = m_prod;
         if (r > 0) begin
            r = r - 1;
            if (r == 0) begin
               hl = p;
               d  = 1'b1;
            end
         end
         if (start && rem == 0) begin
            p = ref_prod(a, b);
            r = W;
         end
         rem    <= r;
         m_done <= d;
         m_hilo <= hl;
         m_prod <= p;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      chk("model_busy", {63'd0, busy}, {63'd0, (rem > 0)});
      chk("model_done", {63'd0, done}, {63'd0, m_done});
      chk("model_hi", {32'd0, hi}, {32'd0, m_hilo[63:32]});
      chk("model_lo", {32'd0, lo}, {32'd0, m_hilo[31:0]});
   end

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < lim) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_timeout", {63'd0, (cyc < lim)}, 64'd1);
   endtask

   task automatic run_product(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int cyc;
      launch(x, y);
      wait_done(100, cyc);
      chk({nm, "_latency"}, 64'(cyc), 64'd32);
      chk({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
      chk({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
   endtask

   initial begin
      int cyc;
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed products with hand-computed results.
      run_product("p6x7", 32'd6, 32'd7, 32'h0, 32'd42);
      run_product("m3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_product("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd1);
      run_product("minxmin", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
      run_product("zeroxmin", 32'h0, 32'h80000000, 32'h0, 32'h0);

      // Start held through RUN with operands changed; held start in DONE relaunches.
      @(negedge clk);
      a = 32'd6; b = 32'd7; start = 1'b1;
      repeat (10) @(negedge clk);
      a = 32'd2; b = 32'd2;
      wait_done(64, cyc);
      chk("held_hi", {32'd0, hi}, 64'd0);
      chk("held_lo", {32'd0, lo}, 64'd42);
      @(negedge clk);
      start = 1'b0;
      chk("relaunch_busy", {63'd0, busy}, 64'd1);
      wait_done(64, cyc);
      chk("relaunch_lo", {32'd0, lo}, 64'd4);

      // Reset mid-run aborts immediately.
      launch(32'd6, 32'd7);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_product("p9x9", 32'd9, 32'd9, 32'h0, 32'd81);

      // Hold the last product with no start.
      run_product("p6x7b", 32'd6, 32'd7, 32'h0, 32'd42);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         chk("hold_lo", {32'd0, lo}, 64'd42);
         chk("hold_done", {63'd0, done}, 64'd0);
      end

      // Randomized traffic, checked every cycle by the model compare.
      for (int it = 0; it < 40; it++) begin
         int g;
         int sel;
         @(negedge clk);
         sel = $urandom_range(0, 7);
         a = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'h0 : $urandom;
         b = (sel == 2) ? 32'h80000000 : (sel == 3) ? 32'hFFFFFFFF : $urandom;
         start = 1'b1;
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
               a = $urandom; b = $urandom;
            end
         end
         start = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
         g = 0;
         while ((busy || done) && g < 200) begin
            @(negedge clk);
            g++;
         end
         chk("rand_drain", {63'd0, (g < 200)}, 64'd1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
